// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises to an incoming Fibonacci LFSR word stream,
// then predicts each word and counts mismatches with saturating counters.
module prbs_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     taps,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 zero_flag
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    return {s[WIDTH-2:0], ^(s & t)};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
  endfunction

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     exp_r, exp_s;
  logic                 seeded_r, seeded_s;
  logic [RUN_W-1:0]     run_r, run_s;
  logic [MISS_W-1:0]    miss_r, miss_s;
  logic                 err_r, err_s;
  logic [CNT_WIDTH-1:0] err_count_r, err_count_s;
  logic [CNT_WIDTH-1:0] word_count_r, word_count_s;
  logic                 zero_flag_r, zero_flag_s;

  // Next-state: clear beats a valid word; gaps in valid_in hold everything except the err pulse
  always_comb begin
    state_s      = state_r;
    exp_s        = exp_r;
    seeded_s     = seeded_r;
    run_s        = run_r;
    miss_s       = miss_r;
    err_s        = 1'b0;
    err_count_s  = err_count_r;
    word_count_s = word_count_r;
    zero_flag_s  = zero_flag_r;
    if (clr) begin
      state_s      = HUNT;
      exp_s        = {WIDTH{1'b0}};
      seeded_s     = 1'b0;
      run_s        = RUN_W'(0);
      miss_s       = MISS_W'(0);
      err_count_s  = CNT_WIDTH'(0);
      word_count_s = CNT_WIDTH'(0);
      zero_flag_s  = 1'b0;
    end else if (valid_in) begin
      if (data_in == {WIDTH{1'b0}}) begin
        zero_flag_s = 1'b1;
      end else begin
        zero_flag_s = zero_flag_r;
      end
      case (state_r)
        HUNT: begin
          exp_s    = step(data_in, taps);
          seeded_s = 1'b1;
          // an all-zero word is the LFSR lock-up state and never counts as a match
          if (seeded_r && (data_in == exp_r) && (data_in != {WIDTH{1'b0}})) begin
            if (run_r == RUN_LAST) begin
              state_s = LOCKED;
              run_s   = RUN_W'(0);
              miss_s  = MISS_W'(0);
            end else begin
              run_s = run_r + RUN_W'(1);
            end
          end else begin
            run_s = RUN_W'(0);
          end
        end
        LOCKED: begin
          exp_s        = step(exp_r, taps);
          word_count_s = sat_inc(word_count_r);
          if (data_in != exp_r) begin
            err_s       = 1'b1;
            err_count_s = sat_inc(err_count_r);
            if (miss_r == MISS_LAST) begin
              state_s = HUNT;
              run_s   = RUN_W'(0);
              miss_s  = MISS_W'(0);
              exp_s   = step(data_in, taps);
            end else begin
              miss_s = miss_r + MISS_W'(1);
            end
          end else begin
            miss_s = MISS_W'(0);
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= HUNT;
      exp_r        <= {WIDTH{1'b0}};
      seeded_r     <= 1'b0;
      run_r        <= RUN_W'(0);
      miss_r       <= MISS_W'(0);
      err_r        <= 1'b0;
      err_count_r  <= CNT_WIDTH'(0);
      word_count_r <= CNT_WIDTH'(0);
      zero_flag_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      exp_r        <= exp_s;
      seeded_r     <= seeded_s;
      run_r        <= run_s;
      miss_r       <= miss_s;
      err_r        <= err_s;
      err_count_r  <= err_count_s;
      word_count_r <= word_count_s;
      zero_flag_r  <= zero_flag_s;
    end
  end

  assign locked     = (state_r == LOCKED);
  assign err        = err_r;
  assign err_count  = err_count_r;
  assign word_count = word_count_r;
  assign zero_flag  = zero_flag_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: vector table, hand sequences and random traffic against an
// orbit-lookup reference model; a 4-bit-counter instance shares the stimulus.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst, clr, valid_in;
  logic [3:0] taps, data_in;

  logic        locked, err, zero_flag;
  logic [15:0] err_count, word_count;
  logic        locked4, err4, zero_flag4;
  logic [3:0]  err_count4, word_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_checker #(.WIDTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .taps(taps), .data_in(data_in), .valid_in(valid_in),
    .locked(locked), .err(err), .err_count(err_count), .word_count(word_count),
    .zero_flag(zero_flag)
  );

  prbs_checker #(.WIDTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .taps(taps), .data_in(data_in), .valid_in(valid_in),
    .locked(locked4), .err(err4), .err_count(err_count4), .word_count(word_count4),
    .zero_flag(zero_flag4)
  );

  // Maximal-length orbit of taps 1100 starting at 0001
  logic [3:0] ref_seq [15];
  int gen_pos;

  // Reference model state
  bit         m_locked, m_seeded, m_err, m_zero;
  logic [3:0] m_last, m_pred;
  int         m_run, m_miss, m_err_tot, m_word_tot;

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         l;
    bit         e;
    int         wc;
    int         ec;
  } vec_t;
  vec_t tbl [19];

  function automatic logic [3:0] succ(input logic [3:0] w);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (ref_seq[i] == w) r = ref_seq[(i + 1) % 15];
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_seeded = 1'b0; m_err = 1'b0; m_zero = 1'b0;
    m_last = 4'h0; m_pred = 4'h0;
    m_run = 0; m_miss = 0; m_err_tot = 0; m_word_tot = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input logic [3:0] d);
    m_err = 1'b0;
    if (c) begin
      m_locked = 1'b0; m_seeded = 1'b0; m_zero = 1'b0;
      m_run = 0; m_miss = 0; m_err_tot = 0; m_word_tot = 0;
    end else if (v) begin
      if (d == 4'h0) m_zero = 1'b1;
      if (!m_locked) begin
        if (m_seeded && d != 4'h0 && d == succ(m_last)) m_run++;
        else m_run = 0;
        m_last = d;
        m_seeded = 1'b1;
        if (m_run == 4) begin
          m_locked = 1'b1; m_miss = 0; m_run = 0; m_pred = succ(d);
        end
      end else begin
        m_word_tot++;
        if (d != m_pred) begin
          m_err = 1'b1; m_err_tot++; m_miss++;
        end else begin
          m_miss = 0;
        end
        m_pred = succ(m_pred);
        if (m_miss == 3) begin
          m_locked = 1'b0; m_run = 0; m_miss = 0; m_last = d;
        end
      end
    end
  endtask

  task automatic check_model();
    check("locked",      int'(locked),      int'(m_locked));
    check("err",         int'(err),         int'(m_err));
    check("err_count",   int'(err_count),   sat(m_err_tot, 16));
    check("word_count",  int'(word_count),  sat(m_word_tot, 16));
    check("zero_flag",   int'(zero_flag),   int'(m_zero));
    check("locked4",     int'(locked4),     int'(m_locked));
    check("err4",        int'(err4),        int'(m_err));
    check("err_count4",  int'(err_count4),  sat(m_err_tot, 4));
    check("word_count4", int'(word_count4), sat(m_word_tot, 4));
    check("zero_flag4",  int'(zero_flag4),  int'(m_zero));
  endtask

  // Drive at a falling edge, let the rising edge sample, compare at the next falling edge
  task automatic cycle(input bit c, input bit v, input logic [3:0] d);
    clr = c; valid_in = v; data_in = d;
    @(posedge clk);
    model_step(c, v, d);
    @(negedge clk);
    check_model();
  endtask

  task automatic send_good();
    cycle(1'b0, 1'b1, ref_seq[gen_pos]);
    gen_pos = (gen_pos + 1) % 15;
  endtask

  task automatic send_bad();
    logic [3:0] mask;
    mask = 4'($urandom_range(1, 15));
    cycle(1'b0, 1'b1, ref_seq[gen_pos] ^ mask);
    gen_pos = (gen_pos + 1) % 15;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_word_count"}, int'(word_count), 0);
    check({tag, "_zero_flag"}, int'(zero_flag), 0);
    check({tag, "_locked4"}, int'(locked4), 0);
    check({tag, "_err_count4"}, int'(err_count4), 0);
  endtask

  initial begin
    ref_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    // lock, single error (0110 -> 0111), gap, 3-word loss, relock after seed + 4 matches
    tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 4'h4, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 4'h9, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 4'h3, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{1'b1, 4'h7, 1'b1, 1'b1, 1, 1};
    tbl[6]  = '{1'b1, 4'hD, 1'b1, 1'b0, 2, 1};
    tbl[7]  = '{1'b1, 4'hA, 1'b1, 1'b0, 3, 1};
    tbl[8]  = '{1'b0, 4'h6, 1'b1, 1'b0, 3, 1};
    tbl[9]  = '{1'b1, 4'h5, 1'b1, 1'b0, 4, 1};
    tbl[10] = '{1'b1, 4'h8, 1'b1, 1'b1, 5, 2};
    tbl[11] = '{1'b1, 4'h8, 1'b1, 1'b1, 6, 3};
    tbl[12] = '{1'b1, 4'h8, 1'b0, 1'b1, 7, 4};
    tbl[13] = '{1'b1, 4'hE, 1'b0, 1'b0, 7, 4};
    tbl[14] = '{1'b1, 4'hC, 1'b0, 1'b0, 7, 4};
    tbl[15] = '{1'b1, 4'h8, 1'b0, 1'b0, 7, 4};
    tbl[16] = '{1'b1, 4'h1, 1'b0, 1'b0, 7, 4};
    tbl[17] = '{1'b1, 4'h2, 1'b1, 1'b0, 7, 4};
    tbl[18] = '{1'b1, 4'h4, 1'b1, 1'b0, 8, 4};

    rst = 1'b0; clr = 1'b0; valid_in = 1'b0; data_in = 4'h0; taps = 4'hC;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].l));
      check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
      check($sformatf("tbl%0d_word_count", i), int'(word_count), tbl[i].wc);
      check($sformatf("tbl%0d_err_count", i), int'(err_count), tbl[i].ec);
      check($sformatf("tbl%0d_zero_flag", i), int'(zero_flag), 0);
    end
    gen_pos = 3;

    // Zero word while locked: sticky flag until clr
    send_good(); send_good();
    cycle(1'b0, 1'b1, 4'h0);
    gen_pos = (gen_pos + 1) % 15;
    check("zero_set", int'(zero_flag), 1);
    repeat (4) send_good();
    check("zero_sticky", int'(zero_flag), 1);
    cycle(1'b1, 1'b0, 4'h0);
    check_all_zero("clr");

    // Saturation: 20 bad words each followed by a good one
    repeat (5) send_good();
    check("sat_locked", int'(locked), 1);
    for (int k = 0; k < 20; k++) begin
      send_bad();
      send_good();
    end
    check("sat_err_count4", int'(err_count4), 15);
    check("sat_word_count4", int'(word_count4), 15);
    check("sat_err_count16", int'(err_count), 20);
    check("sat_locked_after", int'(locked4), 1);
    send_bad();
    check("sat_err_count4_held", int'(err_count4), 15);
    // clr with a valid zero word: clr wins, word discarded
    cycle(1'b1, 1'b1, 4'h0);
    check_all_zero("clr_valid");
    repeat (4) send_good();
    check("after_clr_seed_locked", int'(locked), 0);
    send_good();
    check("after_clr_relocked", int'(locked), 1);

    // Asynchronous reset between edges
    repeat (3) send_good();
    send_bad();
    #2 rst = 1'b0;
    #1;
    check_all_zero("arst");
    check("arst_err4", int'(err4), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) send_good();
    check("arst_relock_early", int'(locked), 0);
    send_good();
    check("arst_relock", int'(locked), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        cycle(1'b0, 1'b0, 4'($urandom));
      end else if (r < 20) begin
        send_bad();
      end else if (r < 22) begin
        repeat (3) send_bad();
      end else if (r < 23) begin
        cycle(1'b1, 1'($urandom), 4'($urandom));
      end else if (r < 24) begin
        cycle(1'b0, 1'b1, 4'($urandom));
      end else begin
        send_good();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer for `LinearFeedbackShiftRegister` outputs. It self-synchronises to the incoming LFSR word stream and predicts each next word from the same tap set. Once locked, it counts mismatched words. It is the receive/check half of the team's PRBS link and BIST path.

## Interface
Parameters:
- `WIDTH`, 4, LFSR word width (≥2); must match the upstream generator.
- `LOCK_CNT`, 4, consecutive correct predictions needed to declare lock (≥1).
- `LOSS_CNT`, 3, consecutive mispredictions while locked that drop lock (≥1).
- `CNT_WIDTH`, 16, width of the saturating counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. While low, all state and outputs are 0.
- `clr`  in  1  synchronous clear: counters and `zero_flag` to 0, state to HUNT, seed invalidated.
- `taps`  in  WIDTH  feedback tap mask; same value as the generator's; static while locked.
- `data_in`  in  WIDTH  received LFSR word.
- `valid_in`  in  1  `data_in` is sampled on edges where this is high.
- `locked`  out  1  checker is in the LOCKED state.
- `err`  out  1  one-cycle pulse: the previous sampled word mismatched while LOCKED.
- `err_count`  out  CNT_WIDTH  mismatches while LOCKED, saturating.
- `word_count`  out  CNT_WIDTH  words checked while LOCKED, saturating.
- `zero_flag`  out  1  sticky: an all-zero word was received (lock-up state).

## Operation
- Step function: `step(S) = {S[WIDTH-2:0], ^(S & taps)}`, a left-shift Fibonacci update with feedback into bit 0.
- Internal registers:
  - `exp` (WIDTH): next expected word.
  - `seeded` (1): `exp` holds a valid seed.
  - `run` (counts 0..LOCK_CNT): consecutive matches in HUNT.
  - `miss` (counts 0..LOSS_CNT): consecutive misses in LOCKED.
- HUNT (reset state): on each valid word:
  - If `seeded` and `data_in==exp` and `data_in!=0`, increment `run`. Otherwise set `run`=0.
  - Always load `exp <= step(data_in)` and set `seeded`=1.
  - When the increment makes `run==LOCK_CNT`, go to LOCKED with `miss`=0.
- LOCKED: on each valid word:
  - `exp <= step(exp)`. `exp` free-runs and is not reloaded from data.
  - Increment `word_count`.
  - If `data_in!=exp`: pulse `err`, increment `err_count`, increment `miss`. Otherwise set `miss`=0.
  - When `miss` reaches LOSS_CNT: go to HUNT, set `run`=0, and load `exp <= step(data_in)`; `seeded` stays 1.
- `zero_flag` sets on any valid word equal to 0, in either state. It clears only on `rst` or `clr`.
- Counters saturate at 2^CNT_WIDTH−1 and do not wrap.
- In HUNT, counters do not change.
- `clr` and `valid_in` in the same cycle: `clr` wins and the word is discarded.
- Changing `taps` while locked is illegal; software must pulse `clr` afterwards.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err`=0, `err_count`=0, `word_count`=0, `zero_flag`=0.
- `locked` rises on the edge that samples the LOCK_CNT-th consecutive match. It is visible the cycle after.
- `err` is high for exactly the one cycle after the edge that sampled the bad word. Back-to-back bad words give back-to-back pulses.
- `locked` falls on the edge that samples the LOSS_CNT-th consecutive miss. The `err` pulse for that word still occurs.
- Gaps in `valid_in` freeze all state. Prediction is indexed by word, not by cycle.
- Relock after loss needs 1 seed word plus LOCK_CNT matches.
- Asserting `rst` mid-operation clears outputs immediately, without waiting for a clock. Deassertion is followed by HUNT with no seed.

## Test plan
Reference sequence: WIDTH=4, `taps`=4'b1100, seeded from 0001. The words are 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then back to 0001.

1. Lock: after reset, feed the reference sequence with `valid_in` held high → `locked` goes to 1 the cycle after word 5 (0011) is sampled; `err` stays 0; `word_count` increments per word from word 6 onward.
2. Single error: once locked, replace 0110 with 0111 → exactly one `err` pulse, `err_count`=1, `locked` stays 1, next word 1101 matches.
3. Loss and relock: once locked, corrupt 3 consecutive words → 3 `err` pulses, `locked` goes to 0 after the 3rd; 5 further good words → `locked` goes back to 1, `err_count`=3.
4. Idle gaps and zero word: insert random `valid_in`=0 gaps during lock → no errors, counts unchanged across the gaps; then send one word 0000 → `zero_flag`=1 and stays set until `clr`.
5. Saturation and clear: with CNT_WIDTH=4, lock and then inject 20 bad words, each pair separated by a good word → `err_count`=15 and held; then assert `clr` together with `valid_in` → all counters 0, `locked`=0, word discarded.
6. Async reset: pull `rst` low between clock edges while locked → all outputs 0 before the next edge; after release, the checker relocks per scenario 1.
